// File: rtl/aes_pkg.sv
// Shared AES definitions: byte counts, the SubBytes engine state type,
// FIPS-197 byte selection and the constant S-box table generators used
// to fill the synchronous ROMs.
package aes_pkg;

   localparam int BLOCK_BYTES = 16;
   localparam int WORD_BYTES  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // FIPS-197 byte idx of a 128-bit value: byte 0 is the most significant byte.
   function automatic logic [7:0] byte_sel(input logic [127:0] data, input logic [3:0] idx);
      return data[8*(15 - int'(idx)) +: 8];
   endfunction

   // 8-bit rotate left by n (0..7).
   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < n; i++) begin
         r = {r[6:0], r[7]};
      end
      return r;
   endfunction

   // Forward S-box, packed so that entry v sits at bits [8v+7:8v].
   // Walks the multiplicative group with generator 3: p steps by *3 while
   // q steps by /3, so q is always the inverse of p; the affine transform
   // of q then gives S(p). Zero has no inverse and maps to 0x63.
   function automatic logic [2047:0] gen_sbox_tbl();
      logic [2047:0] tbl;
      logic [7:0]    p;
      logic [7:0]    q;
      logic [7:0]    x;
      tbl = '0;
      p   = 8'h01;
      q   = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) begin
            q = q ^ 8'h09;
         end
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         tbl[8*int'(p) +: 8] = x ^ 8'h63;
      end
      tbl[7:0] = 8'h63;
      return tbl;
   endfunction

   // Inverse S-box obtained by transposing the forward permutation.
   function automatic logic [2047:0] gen_inv_sbox_tbl();
      logic [2047:0] fwd;
      logic [2047:0] tbl;
      logic [7:0]    s;
      fwd = gen_sbox_tbl();
      tbl = '0;
      for (int v = 0; v < 256; v++) begin
         s = fwd[8*v +: 8];
         tbl[8*int'(s) +: 8] = 8'(v);
      end
      return tbl;
   endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One S-box lane: forward and inverse synchronous ROMs (1-cycle read
// latency) sharing an address, with the result chosen by the registered
// direction bit of the current operation.
import aes_pkg::*;

module sbox_sync (
   input  logic       i_clk,
   input  logic [7:0] i_addr,
   output logic [7:0] o_data
);
   localparam logic [2047:0] TBL = gen_sbox_tbl();

   logic [7:0] r_data;

   // Registered ROM read: address sampled on the rising edge.
   always_ff @(posedge i_clk) begin
      r_data <= TBL[8*int'(i_addr) +: 8];
   end

   assign o_data = r_data;
endmodule

module inv_sbox_sync (
   input  logic       i_clk,
   input  logic [7:0] i_addr,
   output logic [7:0] o_data
);
   localparam logic [2047:0] TBL = gen_inv_sbox_tbl();

   logic [7:0] r_data;

   // Registered ROM read: address sampled on the rising edge.
   always_ff @(posedge i_clk) begin
      r_data <= TBL[8*int'(i_addr) +: 8];
   end

   assign o_data = r_data;
endmodule

module aes_sbox_lane (
   input  logic       i_clk,
   input  logic       i_inv,
   input  logic [7:0] i_addr,
   output logic [7:0] o_data
);
   logic [7:0] w_fwd;
   logic [7:0] w_inv;

   sbox_sync u_fwd (
      .i_clk  (i_clk),
      .i_addr (i_addr),
      .o_data (w_fwd)
   );

   inv_sbox_sync u_inv (
      .i_clk  (i_clk),
      .i_addr (i_addr),
      .o_data (w_inv)
   );

   // i_inv is held constant for the whole operation, so it is valid for
   // the read that completes one cycle after the address was presented.
   assign o_data = i_inv ? w_inv : w_fwd;
endmodule

// File: rtl/aes_subbytes_seq.sv
// SubBytes / SubWord engine. A captured 16-byte block or 4-byte word is
// pushed through LANES parallel S-box lanes, one pass of LANES bytes per
// cycle, with results written back one cycle behind the address issue.
//
// Handshake: i_start is sampled only while idle; the accepting edge
// captures i_in_data/i_inv/i_word and raises o_busy. o_busy stays high for
// PASSES+1 cycles, then o_done pulses for exactly one cycle while o_busy is
// low and o_out_data holds the final result. i_start while busy is dropped
// (no queueing); i_start during the o_done cycle is accepted at its end.
import aes_pkg::*;

module aes_subbytes_seq #(
   parameter int LANES = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic         i_inv,
   input  logic         i_word,
   input  logic [127:0] i_in_data,
   output logic         o_busy,
   output logic         o_done,
   output logic [127:0] o_out_data,
   output logic         o_dbg_state
);

   localparam int BLOCK_PASSES = (BLOCK_BYTES / LANES > 1) ? BLOCK_BYTES / LANES : 1;
   localparam int WORD_PASSES  = (WORD_BYTES / LANES > 1) ? WORD_BYTES / LANES : 1;
   localparam int PCW_RAW      = $clog2(BLOCK_BYTES / LANES + 1);
   localparam int PCW          = (PCW_RAW < 1) ? 1 : PCW_RAW;

   state_t           r_state;
   logic [PCW-1:0]   r_pass;
   logic [PCW-1:0]   r_wb_pass;
   logic             r_wb_valid;
   logic [127:0]     r_op;
   logic             r_inv;
   logic             r_word;
   logic             r_busy;
   logic             r_done;
   logic [127:0]     r_out;

   logic [PCW-1:0]   w_npasses;
   logic             w_issue;
   logic             w_last_wb;
   logic [127:0]     w_out_next;
   logic [7:0]       w_addr   [LANES];
   logic [7:0]       w_lane_q [LANES];
   logic [3:0]       w_iss_idx[LANES];
   logic [3:0]       w_wb_idx [LANES];

   assign w_npasses = r_word ? PCW'(WORD_PASSES) : PCW'(BLOCK_PASSES);

   // A pass is issued every RUN cycle until all passes have been addressed.
   assign w_issue   = (r_state == RUN) && (r_pass != w_npasses);

   // The write-back of the final pass ends the operation.
   assign w_last_wb = r_wb_valid && (r_wb_pass == (w_npasses - 1'b1));

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      // Byte indices are truncated to 4 bits; out-of-range values only
      // occur when the lane is idle or unused and its data is ignored.
      assign w_iss_idx[j] = 4'(int'(r_pass) * LANES + j);
      assign w_wb_idx[j]  = 4'(int'(r_wb_pass) * LANES + j);

      // Word byte i is FIPS block byte 12+i; lanes above 3 idle in word mode.
      if (j < WORD_BYTES) begin : g_word_lane
         assign w_addr[j] = r_word ? byte_sel(r_op, w_iss_idx[j] + 4'd12)
                                   : byte_sel(r_op, w_iss_idx[j]);
      end else begin : g_block_lane
         assign w_addr[j] = r_word ? 8'h00 : byte_sel(r_op, w_iss_idx[j]);
      end

      aes_sbox_lane u_lane (
         .i_clk  (i_clk),
         .i_inv  (r_inv),
         .i_addr (w_addr[j]),
         .o_data (w_lane_q[j])
      );
   end

   // Next result value: the first write-back clears the register so no
   // bytes of the previous result survive (and the word-mode upper bits are
   // zero); later passes overlay their bytes on the partial result.
   always_comb begin
      w_out_next = (r_wb_pass == '0) ? '0 : r_out;
      for (int j = 0; j < LANES; j++) begin
         if (r_word) begin
            if (j < WORD_BYTES) begin
               w_out_next[8*(3 - int'(w_wb_idx[j][1:0])) +: 8] = w_lane_q[j];
            end
         end else begin
            w_out_next[8*(15 - int'(w_wb_idx[j])) +: 8] = w_lane_q[j];
         end
      end
   end

   // Control FSM with pass counter, operand capture and result register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_pass     <= '0;
         r_wb_pass  <= '0;
         r_wb_valid <= 1'b0;
         r_op       <= '0;
         r_inv      <= 1'b0;
         r_word     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_out      <= '0;
      end else begin
         r_done     <= 1'b0;
         r_wb_valid <= w_issue;
         r_wb_pass  <= r_pass;
         if (r_wb_valid) begin
            r_out <= w_out_next;
         end
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= RUN;
                  r_op    <= i_in_data;
                  r_inv   <= i_inv;
                  r_word  <= i_word;
                  r_pass  <= '0;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               if (w_issue) begin
                  r_pass <= r_pass + 1'b1;
               end
               if (w_last_wb) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_out_data  = r_out;
   assign o_dbg_state = (r_state == RUN);

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Bench for aes_subbytes_seq: five instances (LANES 1,2,4,8,16) share the
// same stimulus; each is checked for result, done position, busy width
// and done count against an S-box model built from GF(2^8) arithmetic.
module tb_aes_subbytes_seq;

   localparam int NI = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         inv;
   logic         word;
   logic [127:0] in_data;
   logic         busy [NI];
   logic         done [NI];
   logic [127:0] out  [NI];
   logic         dbg  [NI];

   int total = 0;
   int bad   = 0;

   logic [7:0] m_sbox [256];
   logic [7:0] m_inv  [256];

   typedef struct {
      logic         inv;
      logic         word;
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes_subbytes_seq #(.LANES(1 << g)) u_dut (
         .i_clk       (clk),
         .i_reset     (reset),
         .i_start     (start),
         .i_inv       (inv),
         .i_word      (word),
         .i_in_data   (in_data),
         .o_busy      (busy[g]),
         .o_done      (done[g]),
         .o_out_data  (out[g]),
         .o_dbg_state (dbg[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      if (a == 8'h00) return 8'h00;
      for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] din, input logic v_inv,
                                            input logic v_word);
      logic [127:0] r;
      logic [7:0]   b;
      int           n;
      r = '0;
      n = v_word ? 4 : 16;
      for (int i = 0; i < n; i++) begin
         b = din[8*(n-1-i) +: 8];
         r[8*(n-1-i) +: 8] = v_inv ? m_inv[b] : m_sbox[b];
      end
      return r;
   endfunction

   function automatic int passes(input int g, input logic v_word);
      int p;
      p = (v_word ? 4 : 16) / (1 << g);
      return (p < 1) ? 1 : p;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int g, input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lanes=%0d act=%h exp=%h", name, 1 << g, act, exp);
      end
   endtask

   // One operation on all instances; optional extra start pulse mid-RUN.
   task automatic run_op(input logic v_inv, input logic v_word, input logic [127:0] din,
                         input logic [127:0] exp, input bit mid_start);
      int           bcnt [NI];
      int           dcnt [NI];
      int           dk   [NI];
      logic [127:0] dout [NI];
      for (int g = 0; g < NI; g++) begin
         bcnt[g] = 0; dcnt[g] = 0; dk[g] = -1; dout[g] = '0;
      end
      @(negedge clk);
      inv = v_inv; word = v_word; in_data = din; start = 1'b1;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance: the operands must be captured.
      start = 1'b0; in_data = ~din; inv = ~v_inv; word = ~v_word;
      for (int k = 0; k < 22; k++) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (busy[g]) bcnt[g]++;
            if (done[g]) begin
               dcnt[g]++;
               if (dk[g] < 0) begin
                  dk[g]   = k;
                  dout[g] = out[g];
               end
            end
         end
         if (mid_start && k == 0) begin
            start = 1'b1; in_data = rand128();
         end
         if (mid_start && k == 1) start = 1'b0;
      end
      for (int g = 0; g < NI; g++) begin
         check("done_cycle", g, 128'(dk[g]), 128'(passes(g, v_word) + 1));
         check("busy_width", g, 128'(bcnt[g]), 128'(passes(g, v_word) + 1));
         check("done_count", g, 128'(dcnt[g]), 128'd1);
         check("out_data", g, dout[g], exp);
      end
   endtask

   // start held high: a new operation is accepted at the end of every done
   // cycle, so done recurs every (busy width + 1) cycles.
   task automatic run_held(input logic [127:0] din, input logic [127:0] exp);
      int nxt  [NI];
      int dcnt [NI];
      int ecnt;
      int p;
      for (int g = 0; g < NI; g++) begin
         nxt[g] = passes(g, 1'b0) + 1; dcnt[g] = 0;
      end
      @(negedge clk);
      inv = 1'b0; word = 1'b0; in_data = din; start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (done[g]) begin
               dcnt[g]++;
               check("held_done_at", g, 128'(k), 128'(nxt[g]));
               check("held_out", g, out[g], exp);
               nxt[g] = k + passes(g, 1'b0) + 2;
            end
         end
      end
      start = 1'b0;
      for (int g = 0; g < NI; g++) begin
         p    = passes(g, 1'b0);
         ecnt = 0;
         for (int t = p + 1; t < 60; t += p + 2) ecnt++;
         check("held_done_count", g, 128'(dcnt[g]), 128'(ecnt));
      end
      repeat (25) @(negedge clk);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [127:0] d;
      logic         ri;
      logic         rw;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = gf_inv(8'(x));
         m_sbox[x] = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) m_inv[m_sbox[x]] = 8'(x);

      reset = 1'b1; start = 1'b0; inv = 1'b0; word = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check("reset_busy", g, 128'(busy[g]), 128'd0);
         check("reset_done", g, 128'(done[g]), 128'd0);
         check("reset_out", g, out[g], 128'd0);
         check("reset_state", g, 128'(dbg[g]), 128'd0);
      end

      vecs[0] = '{inv: 1'b0, word: 1'b0, din: 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                  exp: 128'hd42711aee0bf98f1b8b45de51e415230};
      vecs[1] = '{inv: 1'b1, word: 1'b0, din: 128'hd42711aee0bf98f1b8b45de51e415230,
                  exp: 128'h193de3bea0f4e22b9ac68d2ae9f84808};
      vecs[2] = '{inv: 1'b0, word: 1'b1, din: {rand128() >> 32, 32'hcf4f3c09},
                  exp: {96'h0, 32'h8a84eb01}};
      vecs[3] = '{inv: 1'b0, word: 1'b0, din: 128'h0, exp: {16{8'h63}}};
      vecs[4] = '{inv: 1'b1, word: 1'b0, din: {16{8'h63}}, exp: 128'h0};
      vecs[5] = '{inv: 1'b1, word: 1'b1, din: {rand128() >> 32, 32'h8a84eb01},
                  exp: {96'h0, 32'hcf4f3c09}};
      vecs[2].din[127:96] = $urandom();
      vecs[5].din[127:96] = $urandom();

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].inv, vecs[i].word, vecs[i].din, vecs[i].exp, 1'b0);
      end

      for (int i = 0; i < 10; i++) begin
         d  = rand128();
         ri = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         run_op(ri, rw, d, ref_sub(d, ri, rw), 1'b0);
      end

      // start pulsed while every instance is still busy
      d = rand128();
      run_op(1'b0, 1'b0, d, ref_sub(d, 1'b0, 1'b0), 1'b1);
      d = rand128();
      run_op(1'b1, 1'b1, d, ref_sub(d, 1'b1, 1'b1), 1'b1);

      d = rand128();
      run_held(d, ref_sub(d, 1'b0, 1'b0));

      // reset in the middle of a block operation
      @(negedge clk);
      inv = 1'b0; word = 1'b0; in_data = rand128(); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check("midrst_busy", g, 128'(busy[g]), 128'd0);
         check("midrst_done", g, 128'(done[g]), 128'd0);
         check("midrst_out", g, out[g], 128'd0);
      end
      repeat (20) @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         check("midrst_quiet", g, {126'd0, busy[g], done[g]}, 128'd0);
      end
      d = rand128();
      run_op(1'b0, 1'b0, d, ref_sub(d, 1'b0, 1'b0), 1'b0);
      d = rand128();
      run_op(1'b1, 1'b1, d, ref_sub(d, 1'b1, 1'b1), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
